adder_pipe: RTL
===============

Name: adder_pipe

Overview:
Parametrised multi-lane pipelined adder/subtractor. It is the successor to the team's single-cycle combinational adder. It adds configurable lane count and pipeline depth, a valid/ready handshake with backpressure, subtract mode, per-lane overflow flags and optional saturation. It sits between operand producers and datapath consumers wherever sums must be registered at clock rate.

Parameters:
- DATA_WIDTH, 8, operand width per lane (1..64).
- LANES, 4, number of independent lanes sharing one handshake (1..16).
- STAGES, 2, pipeline register stages from accept to output (1..4).
- SATURATE, 0, 1 clamps results on overflow or borrow; 0 wraps.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  [LANES-1:0][DATA_WIDTH-1:0]  packed operand A per lane, unsigned.
- b  input  [LANES-1:0][DATA_WIDTH-1:0]  packed operand B per lane, unsigned.
- sub  input  1  0 computes A+B; 1 computes A-B. Sampled with the beat, applies to all lanes.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result.
- x  output  [LANES-1:0][DATA_WIDTH:0]  packed result per lane.
- ovf  output  [LANES-1:0]  per-lane carry (add) or borrow (sub) of the delivered beat.
- busy  output  1  at least one stage holds a valid beat.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, ports clk and rst.
- Reset values: all stage valid bits cleared. out_valid=0, busy=0, x=0, ovf=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation: in-flight beats are discarded with no output. A beat offered in the reset cycle is not accepted.
- Accept: a beat is accepted when in_valid && in_ready. Result delivery is out_valid && out_ready.
- Pipeline: STAGES registers, each with its own valid bit.
  - Stage k loads when it is empty or stage k+1 loads (or the output transfers, for the last stage).
  - Bubbles collapse.
  - in_ready = !v[0] || stage 1 advances. No combinational path from in_valid to in_ready.
- Latency: accept in cycle N gives out_valid in cycle N+STAGES when there is no backpressure. Throughput is 1 beat/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, x, ovf and out_valid hold stable. Upstream stages fill, then in_ready drops. Maximum buffered beats = STAGES.
- Arithmetic: computed at stage 0 input and registered; later stages only delay.
  - add: r = {1'b0,A} + {1'b0,B}; ovf = r[DATA_WIDTH].
  - sub: r = ({1'b0,A} - {1'b0,B}) mod 2^(DATA_WIDTH+1); ovf = (A < B).
  - SATURATE=0: x = r.
  - SATURATE=1: add with ovf gives x = 2^DATA_WIDTH-1 (MSB 0); sub with ovf gives x = 0; otherwise x = r.
  - Lanes are independent: no carry between lanes.
- Simultaneous accept and deliver with a full pipeline: allowed. Occupancy is unchanged and no beat is lost or duplicated.
- Order: results leave in acceptance order.
- STAGES=1: single register. in_ready = !out_valid || out_ready.

Optional Feature:
- Macro: ADDER_PIPE_OVF_CNT_EN.
- Defined: extra output ovf_cnt [15:0] and input ovf_cnt_clr [1].
  - ovf_cnt increments by popcount(ovf) on each delivered beat and saturates at 16'hFFFF.
  - ovf_cnt_clr=1 zeroes it next cycle and takes priority over an increment in the same cycle.
  - Reset value 0.
- Undefined: ports and counter absent. Behaviour is otherwise identical.

Test Plan:
- Defaults, out_ready=1, a={8'd1,8'd2,8'd255,8'd128}, b={8'd1,8'd3,8'd1,8'd128}, sub=0 -> 2 cycles later x={9'd2,9'd5,9'd256,9'd256}, ovf=4'b0011.
- SATURATE=1, same stimulus -> x={9'd2,9'd5,9'd255,9'd255}, ovf=4'b0011. Then sub with a=3, b=5 in all lanes -> x=0, ovf=4'b1111.
- Sub, SATURATE=0, lane a=5 b=3 -> x=9'd2, ovf=0. Lane a=3 b=5 -> x=9'h1FE, ovf=1.
- Backpressure: stream 10 beats with values 0..9, out_ready low for cycles 3..8 -> in_ready low after 2 buffered beats; all 10 results delivered in order, none dropped or duplicated; x stable while stalled.
- Assert rst for one cycle with 2 beats in flight -> next cycle out_valid=0, busy=0, in_ready=1; no stale result appears afterwards.
- ADDER_PIPE_OVF_CNT_EN defined: deliver 3 beats with ovf=4'b0011 -> ovf_cnt=6. Pulse ovf_cnt_clr in the same cycle as a further overflowing beat -> ovf_cnt=0.

Source files
------------

// File: rtl/adder_pipe.sv
// adder_pipe: multi-lane pipelined adder/subtractor with valid/ready handshake, optional clamping.
// Define ADDER_PIPE_OVF_CNT_EN to add the saturating overflow event counter (ovf_cnt, ovf_cnt_clr).
module adder_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 4,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned SATURATE   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] a,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] b,
  input  logic                             sub,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0][DATA_WIDTH:0]   x,
  output logic [LANES-1:0]                 ovf,
  output logic                             busy
`ifdef ADDER_PIPE_OVF_CNT_EN
  ,
  input  logic                             ovf_cnt_clr,
  output logic [15:0]                      ovf_cnt
`endif
);

  typedef logic [LANES-1:0][DATA_WIDTH:0] lanes_x_t;

  logic [STAGES-1:0]   r_v;
  lanes_x_t            r_x   [STAGES];
  logic [LANES-1:0]    r_ovf [STAGES];

  logic [STAGES-1:0]   w_load;
  logic                w_acc;
  lanes_x_t            w_x;
  logic [LANES-1:0]    w_ovf;
  logic [DATA_WIDTH:0] w_raw;

  always_comb begin
    w_x   = '0;
    w_ovf = '0;
    w_raw = '0;
    for (int l = 0; l < LANES; l++) begin
      if (sub) begin
        w_raw = {1'b0, a[l]} - {1'b0, b[l]};
      end else begin
        w_raw = {1'b0, a[l]} + {1'b0, b[l]};
      end
      w_ovf[l] = sub ? (a[l] < b[l]) : w_raw[DATA_WIDTH];
      if ((SATURATE != 0) && w_ovf[l]) begin
        w_x[l] = sub ? '0 : {1'b0, {DATA_WIDTH{1'b1}}};
      end else begin
        w_x[l] = w_raw;
      end
    end
  end

  // A stage loads if it or any later stage has a hole, or the output drains; bubbles collapse.
  always_comb begin
    w_load = '0;
    w_acc  = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_acc     = w_acc || !r_v[k];
      w_load[k] = w_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_x[k]   <= '0;
        r_ovf[k] <= '0;
      end
    end else begin
      if (w_load[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_x[0]   <= w_x;
          r_ovf[0] <= w_ovf;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k] <= r_v[k-1];
          if (r_v[k-1]) begin
            r_x[k]   <= r_x[k-1];
            r_ovf[k] <= r_ovf[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_v[STAGES-1];
  assign x         = r_x[STAGES-1];
  assign ovf       = r_ovf[STAGES-1];
  assign busy      = |r_v;

`ifdef ADDER_PIPE_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;
  logic [4:0]  w_pop;
  logic [16:0] w_cnt_sum;

  always_comb begin
    w_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pop = w_pop + {4'b0, ovf[l]};
    end
    w_cnt_sum = {1'b0, r_ovf_cnt} + {12'b0, w_pop};
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || ovf_cnt_clr) begin
      r_ovf_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_ovf_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

endmodule
